// File: rtl/apb3_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb3_timer_pkg
// Purpose  : Shared register map, CTRL bit positions and APB FSM encoding
// Revision : 1.0
// ============================================================================
package apb3_timer_pkg;

    localparam logic [11:0] c_addr_ctrl   = 12'h000;
    localparam logic [11:0] c_addr_presc  = 12'h004;
    localparam logic [11:0] c_addr_load   = 12'h008;
    localparam logic [11:0] c_addr_count  = 12'h00C;
    localparam logic [11:0] c_addr_status = 12'h010;
    localparam logic [11:0] c_addr_duty   = 12'h014;

    localparam int c_ctrl_en      = 0;
    localparam int c_ctrl_oneshot = 1;
    localparam int c_ctrl_irq_en  = 2;

    localparam logic [31:0] c_load_rst = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        APB_IDLE = 2'd0,
        APB_WAIT = 2'd1,
        APB_DONE = 2'd2
    } apb_state_e;

endpackage
`default_nettype wire

// File: rtl/apb3_timer_core.sv
`default_nettype none
// ============================================================================
// Module   : apb3_timer_core
// Purpose  : Prescaler, 32-bit counter, compare/reload, MATCH, IRQ and PWM.
//            Optional DUTY/PWM logic is built when APB3_TIMER_PWM_EN is defined.
// Revision : 1.0
// ============================================================================
module apb3_timer_core
    import apb3_timer_pkg::*;
#(
    parameter logic [15:0] RST_PRESC = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_wdata,
    input  logic        i_ctrl_we,
    input  logic        i_presc_we,
    input  logic        i_load_we,
    input  logic        i_status_w1c,
`ifdef APB3_TIMER_PWM_EN
    input  logic        i_duty_we,
    output logic [31:0] o_duty,
`endif
    output logic        o_en,
    output logic        o_oneshot,
    output logic        o_irq_en,
    output logic [15:0] o_presc,
    output logic [31:0] o_load,
    output logic [31:0] o_count,
    output logic        o_match,
    output logic        o_irq,
    output logic        o_pwm
);

    logic        en_q, en_d;
    logic        oneshot_q, oneshot_d;
    logic        irq_en_q, irq_en_d;
    logic [15:0] presc_q, presc_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic [31:0] load_q, load_d;
    logic [31:0] count_q, count_d;
    logic        match_q, match_d;
    logic        irq_q;
    logic        w_tick;
    logic        w_wrap;

    always_comb begin
        en_d      = en_q;
        oneshot_d = oneshot_q;
        irq_en_d  = irq_en_q;
        presc_d   = presc_q;
        load_d    = load_q;
        count_d   = count_q;
        pcnt_d    = pcnt_q;
        match_d   = match_q;
        w_tick    = 1'b0;
        w_wrap    = 1'b0;

        // >= rather than == so a PRESC lowered below pcnt cannot stall for 2^16 cycles
        if (en_q) begin
            if (pcnt_q >= presc_q) begin
                pcnt_d = 16'd0;
                w_tick = 1'b1;
            end else begin
                pcnt_d = pcnt_q + 16'd1;
            end
        end

        if (w_tick) begin
            if (count_q >= load_q) begin
                w_wrap  = 1'b1;
                count_d = 32'd0;
                if (oneshot_q) en_d = 1'b0;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        if (i_ctrl_we) begin
            en_d      = i_wdata[c_ctrl_en];
            oneshot_d = i_wdata[c_ctrl_oneshot];
            irq_en_d  = i_wdata[c_ctrl_irq_en];
            if (!en_q && i_wdata[c_ctrl_en]) begin
                count_d = 32'd0;
                pcnt_d  = 16'd0;
            end
        end
        if (i_presc_we) presc_d = i_wdata[15:0];
        if (i_load_we)  load_d  = i_wdata;

        // A match on the same edge as the clear must not be lost
        if (i_status_w1c && i_wdata[0]) match_d = 1'b0;
        if (w_wrap)                     match_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            en_q      <= 1'b0;
            oneshot_q <= 1'b0;
            irq_en_q  <= 1'b0;
            presc_q   <= RST_PRESC;
            pcnt_q    <= 16'd0;
            load_q    <= c_load_rst;
            count_q   <= 32'd0;
            match_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            en_q      <= en_d;
            oneshot_q <= oneshot_d;
            irq_en_q  <= irq_en_d;
            presc_q   <= presc_d;
            pcnt_q    <= pcnt_d;
            load_q    <= load_d;
            count_q   <= count_d;
            match_q   <= match_d;
            irq_q     <= match_q & irq_en_q;
        end
    end

`ifdef APB3_TIMER_PWM_EN
    logic [31:0] duty_q, duty_d;
    logic        pwm_q, pwm_d;

    always_comb begin
        duty_d = i_duty_we ? i_wdata : duty_q;
        pwm_d  = en_q & (count_q < duty_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            duty_q <= 32'd0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign o_duty = duty_q;
    assign o_pwm  = pwm_q;
`else
    assign o_pwm  = 1'b0;
`endif

    assign o_en      = en_q;
    assign o_oneshot = oneshot_q;
    assign o_irq_en  = irq_en_q;
    assign o_presc   = presc_q;
    assign o_load    = load_q;
    assign o_count   = count_q;
    assign o_match   = match_q;
    assign o_irq     = irq_q;

endmodule
`default_nettype wire

// File: rtl/apb3_timer.sv
`default_nettype none
// ============================================================================
// Module   : apb3_timer
// Purpose  : APB3 timer peripheral; one-wait-state register front end around
//            apb3_timer_core. DUTY/PWM enabled by APB3_TIMER_PWM_EN.
// Revision : 1.0
// ============================================================================
module apb3_timer
    import apb3_timer_pkg::*;
#(
    parameter int          APB3_ADDR_WIDTH = 32,
    parameter int          APB3_DATA_WIDTH = 32,
    parameter logic [15:0] RST_PRESC       = 16'h0000
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_psel,
    input  logic                       i_penable,
    input  logic                       i_pwrite,
    input  logic [APB3_ADDR_WIDTH-1:0] i_paddr,
    input  logic [APB3_DATA_WIDTH-1:0] i_pwdata,
    output logic [APB3_DATA_WIDTH-1:0] o_prdata,
    output logic                       o_pready,
    output logic                       o_pslverr,
    output logic                       o_irq,
    output logic                       o_pwm
);

    apb_state_e  state_q, state_d;
    logic [31:0] prdata_q, prdata_d;
    logic        err_q, err_d;

    logic [11:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_hit;
    logic        w_err;
    logic        w_ctrl_we, w_presc_we, w_load_we, w_status_w1c;
    logic        w_en, w_oneshot, w_irq_en, w_match;
    logic [15:0] w_presc;
    logic [31:0] w_load, w_count;
    logic        w_unused_paddr;

    assign w_addr         = {i_paddr[11:2], 2'b00};
    assign w_unused_paddr = ^{i_paddr[APB3_ADDR_WIDTH-1:12], i_paddr[1:0]};

`ifdef APB3_TIMER_PWM_EN
    logic        w_duty_we;
    logic [31:0] w_duty;
`endif

    always_comb begin
        w_rdata = 32'd0;
        w_hit   = 1'b1;
        case (w_addr)
            c_addr_ctrl:   w_rdata = {29'd0, w_irq_en, w_oneshot, w_en};
            c_addr_presc:  w_rdata = {16'd0, w_presc};
            c_addr_load:   w_rdata = w_load;
            c_addr_count:  w_rdata = w_count;
            c_addr_status: w_rdata = {31'd0, w_match};
`ifdef APB3_TIMER_PWM_EN
            c_addr_duty:   w_rdata = w_duty;
`endif
            default:       w_hit   = 1'b0;
        endcase
        w_err = !w_hit || (i_pwrite && (w_addr == c_addr_count));
    end

    always_comb begin
        state_d      = state_q;
        prdata_d     = prdata_q;
        err_d        = err_q;
        w_ctrl_we    = 1'b0;
        w_presc_we   = 1'b0;
        w_load_we    = 1'b0;
        w_status_w1c = 1'b0;
`ifdef APB3_TIMER_PWM_EN
        w_duty_we    = 1'b0;
`endif
        case (state_q)
            APB_IDLE: begin
                if (i_psel && !i_penable) state_d = APB_WAIT;
            end
            APB_WAIT: begin
                if (!i_psel) begin
                    state_d = APB_IDLE;
                end else begin
                    prdata_d = (!i_pwrite && !w_err) ? w_rdata : 32'd0;
                    err_d    = w_err;
                    state_d  = APB_DONE;
                end
            end
            APB_DONE: begin
                state_d = APB_IDLE;
                // Bus is held stable through the access phase, so decode live
                if (i_pwrite && !err_q) begin
                    w_ctrl_we    = (w_addr == c_addr_ctrl);
                    w_presc_we   = (w_addr == c_addr_presc);
                    w_load_we    = (w_addr == c_addr_load);
                    w_status_w1c = (w_addr == c_addr_status);
`ifdef APB3_TIMER_PWM_EN
                    w_duty_we    = (w_addr == c_addr_duty);
`endif
                end
            end
            default: state_d = APB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= APB_IDLE;
            prdata_q <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prdata_q <= prdata_d;
            err_q    <= err_d;
        end
    end

    assign o_prdata  = prdata_q;
    assign o_pready  = (state_q == APB_DONE);
    assign o_pslverr = (state_q == APB_DONE) && err_q;

    apb3_timer_core #(
        .RST_PRESC (RST_PRESC)
    ) u_core (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_wdata      (i_pwdata),
        .i_ctrl_we    (w_ctrl_we),
        .i_presc_we   (w_presc_we),
        .i_load_we    (w_load_we),
        .i_status_w1c (w_status_w1c),
`ifdef APB3_TIMER_PWM_EN
        .i_duty_we    (w_duty_we),
        .o_duty       (w_duty),
`endif
        .o_en         (w_en),
        .o_oneshot    (w_oneshot),
        .o_irq_en     (w_irq_en),
        .o_presc      (w_presc),
        .o_load       (w_load),
        .o_count      (w_count),
        .o_match      (w_match),
        .o_irq        (o_irq),
        .o_pwm        (o_pwm)
    );

endmodule
`default_nettype wire

// File: tb/tb_apb3_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb3_timer
// Purpose  : Self-checking bench for apb3_timer: register table, directed
//            timing sequences and randomized timer runs against an
//            elapsed-cycle arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_apb3_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr, irq, pwm;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb3_timer #(
        .APB3_ADDR_WIDTH (32),
        .APB3_DATA_WIDTH (32),
        .RST_PRESC       (16'h0000)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_psel    (psel),
        .i_penable (penable),
        .i_pwrite  (pwrite),
        .i_paddr   (paddr),
        .i_pwdata  (pwdata),
        .o_prdata  (prdata),
        .o_pready  (pready),
        .o_pslverr (pslverr),
        .o_irq     (irq),
        .o_pwm     (pwm)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Full APB transfer; snap is the edge count whose resulting state the read reflects
    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int snap);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(negedge clk);
        penable = 1'b1;
        snap    = cyc;
        check("pready_wait_state", {31'd0, pready}, 32'd0);
        @(negedge clk);
        check("pready_access2", {31'd0, pready}, 32'd1);
        rdata = prdata;
        err   = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    logic [31:0] rdv;
    logic        erv;
    int          snv;

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        apb(1'b1, addr, data, rdv, erv, snv);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        apb(1'b0, addr, 32'd0, rdv, erv, snv);
        check(name, rdv, exp);
    endtask

    task automatic wait_until(input int target);
        check("schedule_not_late", {31'd0, (cyc <= target)}, 32'd1);
        for (int k = 0; k < 1000 && cyc < target; k++) @(negedge clk);
    endtask

    task automatic wait_irq_rise(input string name, input int exp_cyc);
        int rise = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (irq) begin
                rise = cyc;
                break;
            end
        end
        check(name, rise, exp_cyc);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int e0;
        int p, l, t;
        logic os, ie;
        logic [31:0] exp_count;
        logic        exp_match, exp_en;

        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'd0; pwdata = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_prdata", prdata, 32'd0);
        check("reset_flags", {28'd0, pready, pslverr, irq, pwm}, 32'd0);
        rst = 1'b0;

        // Put the timer in a busy state so reset has something to clear
        wr(32'h04, 32'd0);
        wr(32'h08, 32'd0);
        wr(32'h00, 32'h5);
        repeat (4) @(negedge clk);
        check("irq_before_reset", {31'd0, irq}, 32'd1);

        // Reset three cycles in the middle of a write to LOAD
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h55;
        @(negedge clk);
        penable = 1'b1;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_prdata", prdata, 32'd0);
        check("midrst_flags", {28'd0, pready, pslverr, irq, pwm}, 32'd0);
        rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;

        vecs.push_back('{1'b0, 32'h000, 32'h0,         32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h004, 32'h0,         32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h008, 32'h0,         32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{1'b0, 32'h00C, 32'h0,         32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h010, 32'h0,         32'h0,         1'b0});
`ifdef APB3_TIMER_PWM_EN
        vecs.push_back('{1'b0, 32'h014, 32'h0,         32'h0,         1'b0});
`else
        vecs.push_back('{1'b0, 32'h014, 32'h0,         32'h0,         1'b1});
`endif
        vecs.push_back('{1'b1, 32'h008, 32'h10,        32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h008, 32'h0,         32'h10,        1'b0});
        vecs.push_back('{1'b0, 32'h00B, 32'h0,         32'h10,        1'b0});
        vecs.push_back('{1'b1, 32'h004, 32'h1234_5678, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h004, 32'h0,         32'h5678,      1'b0});
        vecs.push_back('{1'b1, 32'h000, 32'hFFFF_FFF6, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h000, 32'h0,         32'h6,         1'b0});
        vecs.push_back('{1'b1, 32'h000, 32'h0,         32'h0,         1'b0});
        vecs.push_back('{1'b1, 32'h00C, 32'h5,         32'h0,         1'b1});
        vecs.push_back('{1'b0, 32'h00C, 32'h0,         32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h020, 32'h0,         32'h0,         1'b1});
        vecs.push_back('{1'b1, 32'h020, 32'hAB,        32'h0,         1'b1});
        vecs.push_back('{1'b0, 32'h1008, 32'h0,        32'h10,        1'b0});
        vecs.push_back('{1'b1, 32'h004, 32'h0,         32'h0,         1'b0});

        foreach (vecs[i]) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rdv, erv, snv);
            check($sformatf("vec%0d_pslverr", i), {31'd0, erv}, {31'd0, vecs[i].exp_err});
            if (!vecs[i].wr)
                check($sformatf("vec%0d_prdata", i), rdv, vecs[i].exp_rdata);
        end

        // Periodic: PRESC=1, LOAD=3 -> match every 8 cycles, irq one cycle later
        wr(32'h00, 32'h0);
        wr(32'h10, 32'h1);
        wr(32'h04, 32'h1);
        wr(32'h08, 32'h3);
        wr(32'h00, 32'h5);
        e0 = snv + 2;
        wait_irq_rise("periodic_irq_rise1", e0 + 9);
        wr(32'h10, 32'h1);
        @(negedge clk);
        check("periodic_irq_cleared", {31'd0, irq}, 32'd0);
        wait_irq_rise("periodic_irq_rise2", e0 + 17);
`ifndef APB3_TIMER_PWM_EN
        check("pwm_tied_low", {31'd0, pwm}, 32'd0);
`endif

        // One-shot: LOAD=2, PRESC=0 -> single match, EN self-clears, COUNT parks at 0
        wr(32'h00, 32'h0);
        wr(32'h10, 32'h1);
        wr(32'h04, 32'h0);
        wr(32'h08, 32'h2);
        wr(32'h00, 32'h3);
        repeat (10) @(negedge clk);
        rd_chk("oneshot_status", 32'h10, 32'h1);
        rd_chk("oneshot_ctrl", 32'h00, 32'h2);
        rd_chk("oneshot_count", 32'h0C, 32'h0);
        check("oneshot_irq_masked", {31'd0, irq}, 32'd0);

        // LOAD lowered below a running COUNT, then W1C racing a fresh match
        wr(32'h00, 32'h0);
        wr(32'h10, 32'h1);
        wr(32'h04, 32'h3);
        wr(32'h08, 32'd100);
        wr(32'h00, 32'h1);
        e0 = snv + 2;
        wait_until(e0 + 38);
        wr(32'h08, 32'h5);
        rd_chk("lower_load_count", 32'h0C, 32'h0);
        rd_chk("lower_load_match", 32'h10, 32'h1);
        wr(32'h10, 32'h1);
        rd_chk("w1c_clears", 32'h10, 32'h0);
        wait_until(e0 + 64);
        wr(32'h10, 32'h1);
        rd_chk("set_beats_w1c", 32'h10, 32'h1);

        // Randomized runs: expected state derived from elapsed cycles since enable
        for (int it = 0; it < 20; it++) begin
            p  = int'($urandom_range(0, 3));
            l  = int'($urandom_range(0, 6));
            os = 1'($urandom_range(0, 1));
            ie = 1'($urandom_range(0, 1));
            wr(32'h00, 32'h0);
            wr(32'h10, 32'h1);
            wr(32'h04, 32'(p));
            wr(32'h08, 32'(l));
            wr(32'h00, {29'd0, ie, os, 1'b1});
            e0 = snv + 2;
            repeat ($urandom_range(0, 30)) @(negedge clk);

            apb(1'b0, 32'h0C, 32'd0, rdv, erv, snv);
            t = (snv - e0) / (p + 1);
            exp_count = (t >= l + 1 && os) ? 32'd0 : 32'(t % (l + 1));
            check($sformatf("rand%0d_count", it), rdv, exp_count);

            apb(1'b0, 32'h10, 32'd0, rdv, erv, snv);
            t = (snv - e0) / (p + 1);
            exp_match = (t >= l + 1);
            check($sformatf("rand%0d_match", it), rdv, {31'd0, exp_match});

            apb(1'b0, 32'h00, 32'd0, rdv, erv, snv);
            t = (snv - e0) / (p + 1);
            exp_en = os ? (t < l + 1) : 1'b1;
            check($sformatf("rand%0d_ctrl", it), rdv, {29'd0, ie, os, exp_en});

            t = (cyc - 1 - e0) / (p + 1);
            check($sformatf("rand%0d_irq", it), {31'd0, irq}, {31'd0, ie & (t >= l + 1)});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
